memory_responder: RTL and testbench

MEMORY_RESPONDER -- requirements
Module: memory_responder

---
 rtl/memory_responder.sv | 137 +++++++++++++
 tb/tb_memory_responder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// Single-port word memory answering one Read or Write request at a time.
// Optional wait states are enabled by defining MEM_WAIT_STATES_EN.
module memory_responder #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              Read,
    input  logic              Write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [2:0]        wait_cfg,
    output logic [DATA_W-1:0] Mdatain,
    output logic              mem_ready,
    output logic              mem_busy,
    output logic              mem_err
);

`ifdef MEM_WAIT_STATES_EN
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
`else
    typedef enum logic [0:0] {IDLE = 1'b0, RESP = 1'b1} state_t;
`endif

    state_t              state_q, state_d;
    logic                armed_q, armed_d;
    logic                op_wr_q, op_wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;
`ifdef MEM_WAIT_STATES_EN
    logic [2:0]          cnt_q, cnt_d;
`else
    logic                unused_wait_cfg;
    assign unused_wait_cfg = ^wait_cfg;
`endif

    // Storage is deliberately outside the reset domain.
    logic [DATA_W-1:0]   mem [2**ADDR_W];

    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        op_wr_d = op_wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
`ifdef MEM_WAIT_STATES_EN
        cnt_d   = cnt_q;
`endif
        // Re-arm only once both request levels are seen low.
        if (!Read && !Write)
            armed_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (armed_q && Read && Write) begin
                    err_d = 1'b1;
                end else if (armed_q && (Read ^ Write)) begin
                    op_wr_d = Write;
                    addr_d  = addr;
                    wdata_d = wdata;
                    armed_d = 1'b0;
`ifdef MEM_WAIT_STATES_EN
                    if (wait_cfg != 3'd0) begin
                        cnt_d   = wait_cfg;
                        state_d = WAIT;
                    end else begin
                        state_d = RESP;
                    end
`else
                    state_d = RESP;
`endif
                end
            end
`ifdef MEM_WAIT_STATES_EN
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1)
                    state_d = RESP;
            end
`endif
            RESP: begin
                ready_d = 1'b1;
                state_d = IDLE;
                if (!op_wr_q)
                    rdata_d = mem[addr_q];
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            armed_q <= 1'b1;
            op_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
`ifdef MEM_WAIT_STATES_EN
            cnt_q   <= 3'd0;
`endif
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            op_wr_q <= op_wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
`ifdef MEM_WAIT_STATES_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // A reset taken before the RESP edge forces IDLE, so no commit happens.
    always_ff @(posedge clk) begin
        if (state_q == RESP && op_wr_q)
            mem[addr_q] <= wdata_q;
    end

    assign Mdatain   = rdata_q;
    assign mem_ready = ready_q;
    assign mem_busy  = (state_q != IDLE);
    assign mem_err   = err_q;

endmodule

// File: tb/tb_memory_responder.sv
// Randomized bench for memory_responder with a transaction-level reference model
// plus directed scenarios carrying hand-computed expectations.
module tb_memory_responder;

`ifdef MEM_WAIT_STATES_EN
    localparam bit WS = 1'b1;
`else
    localparam bit WS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        Read = 1'b0;
    logic        Write = 1'b0;
    logic [8:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [2:0]  wait_cfg = '0;
    logic [31:0] Mdatain;
    logic        mem_ready, mem_busy, mem_err;

    memory_responder #(.ADDR_W(9), .DATA_W(32)) dut (
        .clk(clk), .clr(clr), .Read(Read), .Write(Write), .addr(addr),
        .wdata(wdata), .wait_cfg(wait_cfg), .Mdatain(Mdatain),
        .mem_ready(mem_ready), .mem_busy(mem_busy), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction, completing W+1 edges after capture.
    logic [31:0] mm [512];
    bit          pend = 1'b0;
    bit          pend_rd = 1'b0;
    logic [8:0]  pend_a = '0;
    logic [31:0] pend_d = '0;
    longint      pend_done = 0;
    longint      cyc = 0;
    bit          m_armed = 1'b1;
    bit          m_idle = 1'b1;
    int          m_w = 0;
    logic [31:0] e_rdata = '0;
    bit          e_ready = 1'b0, e_busy = 1'b0, e_err = 1'b0;

    always @(posedge clk) begin
        cyc++;
        e_ready = 1'b0;
        e_err   = 1'b0;
        if (!clr) begin
            pend    = 1'b0;
            m_armed = 1'b1;
            e_rdata = '0;
            e_busy  = 1'b0;
        end else begin
            m_idle = !pend;
            if (pend && cyc == pend_done) begin
                if (pend_rd) e_rdata = mm[pend_a];
                else         mm[pend_a] = pend_d;
                pend    = 1'b0;
                e_ready = 1'b1;
            end
            if (m_idle && m_armed && Read && Write) begin
                e_err = 1'b1;
            end else if (m_idle && m_armed && (Read ^ Write)) begin
                m_w       = WS ? int'(wait_cfg) : 0;
                pend      = 1'b1;
                pend_rd   = Read;
                pend_a    = addr;
                pend_d    = wdata;
                pend_done = cyc + m_w + 1;
                m_armed   = 1'b0;
            end else if (!Read && !Write) begin
                m_armed = 1'b1;
            end
            e_busy = pend;
        end
        #1;
        check("mem_ready", {31'd0, mem_ready}, {31'd0, e_ready});
        check("mem_busy",  {31'd0, mem_busy},  {31'd0, e_busy});
        check("mem_err",   {31'd0, mem_err},   {31'd0, e_err});
        check("Mdatain",   Mdatain, e_rdata);
    end

    // Drive one request, hold it `hold` cycles, then scramble the bus while observing 12 cycles.
    task automatic access(input bit rd, input bit wr, input logic [8:0] a, input logic [31:0] d,
                          input logic [2:0] w, input int hold, input logic [8:0] alt,
                          output int lat, output int nbusy, output int nready, output int nerr);
        @(negedge clk);
        Read = rd; Write = wr; addr = a; wdata = d; wait_cfg = w;
        lat = 0; nbusy = 0; nready = 0; nerr = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (mem_busy) nbusy++;
            if (mem_ready) begin
                nready++;
                if (lat == 0) lat = n;
            end
            if (mem_err) nerr++;
            if (n >= hold) begin
                Read = 1'b0;
                Write = 1'b0;
            end
            addr = alt;
            wdata = $urandom;
            wait_cfg = 3'($urandom);
        end
    endtask

    task automatic wr_word(input logic [8:0] a, input logic [31:0] d);
        int lat, nb, nr, ne;
        access(1'b0, 1'b1, a, d, 3'd0, 1, a, lat, nb, nr, ne);
        check("preload_ready_count", nr, 1);
    endtask

    logic [8:0] pool [8];
    int lat, nb, nr, ne, kind;

    initial begin
        pool[0] = 9'h000; pool[1] = 9'h003; pool[2] = 9'h004; pool[3] = 9'h005;
        pool[4] = 9'h010; pool[5] = 9'h0A5; pool[6] = 9'h1FE; pool[7] = 9'h1FF;

        repeat (3) @(negedge clk);
        check("rst_Mdatain", Mdatain, 32'h0);
        check("rst_ready", {31'd0, mem_ready}, 32'd0);
        check("rst_busy",  {31'd0, mem_busy},  32'd0);
        check("rst_err",   {31'd0, mem_err},   32'd0);
        clr = 1'b1;

        // Write then read back, zero wait states.
        access(1'b0, 1'b1, 9'h005, 32'hDEADBEEF, 3'd0, 1, 9'h006, lat, nb, nr, ne);
        check("wr005_latency", lat, 2);
        check("wr005_busy", nb, 1);
        access(1'b1, 1'b0, 9'h005, 32'h0, 3'd0, 1, 9'h006, lat, nb, nr, ne);
        check("rd005_latency", lat, 2);
        check("rd005_data", Mdatain, 32'hDEADBEEF);

        wr_word(9'h003, 32'h33333333);
        wr_word(9'h004, 32'h44444444);
        wr_word(9'h010, 32'h01010101);
        wr_word(9'h1FF, 32'h12345678);
        wr_word(9'h000, 32'h0BADF00D);
        wr_word(9'h0A5, 32'hA5A5A5A5);
        wr_word(9'h1FE, 32'hFEFEFEFE);
        check("write_keeps_Mdatain", Mdatain, 32'hDEADBEEF);

        // Top address with three wait states (collapses to zero without the option).
        access(1'b1, 1'b0, 9'h1FF, 32'h0, 3'd3, 1, 9'h000, lat, nb, nr, ne);
        check("rd1ff_latency", lat, WS ? 5 : 2);
        check("rd1ff_busy", nb, WS ? 4 : 1);
        check("rd1ff_data", Mdatain, 32'h12345678);

        // Held Read completes once; re-arms only after it drops.
        access(1'b1, 1'b0, 9'h004, 32'h0, 3'd1, 10, 9'h004, lat, nb, nr, ne);
        check("held_read_ready_count", nr, 1);
        check("held_read_data", Mdatain, 32'h44444444);
        access(1'b1, 1'b0, 9'h003, 32'h0, 3'd0, 1, 9'h003, lat, nb, nr, ne);
        check("rearm_ready_count", nr, 1);
        check("rearm_data", Mdatain, 32'h33333333);

        // Both requests high: error pulse, no access.
        access(1'b1, 1'b1, 9'h005, 32'h11111111, 3'd0, 1, 9'h005, lat, nb, nr, ne);
        check("both_err_count", ne, 1);
        check("both_busy", nb, 0);
        check("both_ready", nr, 0);
        access(1'b1, 1'b0, 9'h005, 32'h0, 3'd0, 1, 9'h005, lat, nb, nr, ne);
        check("both_mem_unchanged", Mdatain, 32'hDEADBEEF);

        // Reset in flight aborts the write.
        @(negedge clk);
        Write = 1'b1; addr = 9'h010; wdata = 32'hAAAA5555; wait_cfg = 3'd5;
        @(negedge clk);
        Write = 1'b0;
        clr = 1'b0;
        #1;
        check("abort_Mdatain", Mdatain, 32'h0);
        check("abort_ready", {31'd0, mem_ready}, 32'd0);
        check("abort_busy",  {31'd0, mem_busy},  32'd0);
        check("abort_err",   {31'd0, mem_err},   32'd0);
        repeat (2) @(negedge clk);
        clr = 1'b1;
        access(1'b1, 1'b0, 9'h010, 32'h0, 3'd0, 1, 9'h010, lat, nb, nr, ne);
        check("abort_first_ready", nr, 1);
        check("abort_prior_data", Mdatain, 32'h01010101);

        // Address moved while in flight.
        access(1'b1, 1'b0, 9'h003, 32'h0, 3'd2, 1, 9'h004, lat, nb, nr, ne);
        check("addr_change_data", Mdatain, 32'h33333333);
        check("addr_change_latency", lat, WS ? 4 : 2);

        // Random traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            kind = int'($urandom_range(0, 99));
            Read  = (kind >= 60 && kind < 80) || (kind >= 95);
            Write = (kind >= 80);
            addr = pool[$urandom_range(0, 7)];
            wdata = $urandom;
            wait_cfg = 3'($urandom);
            clr = ($urandom_range(0, 199) != 0);
        end
        @(negedge clk);
        Read = 1'b0; Write = 1'b0; clr = 1'b1;
        repeat (12) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
